// File: rtl/fifo_uart_tx_if.sv
// Read-side connection between the synchronous 8-bit FIFO and the fifo_uart_tx drain stage.
// master: the drain stage (owns r_en). slave: the FIFO (owns empty/data).
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_r_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_r_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_r_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO and serialises each byte: start, 8 data bits LSB first, optional even parity, stop.
// Define FIFO_UART_TX_PARITY_EN to compile in the parity bit (11-bit frames instead of 10).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd6
  } state_t;
`endif

  state_t        state_r;
  state_t        state_next_s;
  logic [BW-1:0] baud_r;
  logic [BW-1:0] baud_next_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_next_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_next_s;
  logic          baud_done_s;
  logic          tx_next_s;
  logic          busy_next_s;
  logic          frame_done_next_s;
  logic          r_en_next_s;

`ifdef FIFO_UART_TX_PARITY_EN
  logic parity_r;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  // Parity is latched together with the byte, since the shifter is consumed while sending
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (state_r == LOAD) begin
      parity_r <= even_parity(fifo.fifo_data);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Next-state, counter and shifter logic; the baud counter restarts on every bit boundary
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = '0;
    bit_next_s   = bit_r;
    shift_next_s = shift_r;
    baud_done_s  = (baud_r == BAUD_LAST);
    case (state_r)
      IDLE: begin
        if (!fifo.fifo_empty) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        state_next_s = LOAD;
      end
      LOAD: begin
        shift_next_s = fifo.fifo_data;
        state_next_s = START;
      end
      START: begin
        if (baud_done_s) begin
          state_next_s = DATA;
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
      DATA: begin
        if (baud_done_s) begin
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_next_s = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_next_s = PARITY;
`else
            state_next_s = STOP;
`endif
          end else begin
            bit_next_s = bit_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done_s) begin
          state_next_s = STOP;
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done_s) begin
          // Only the stop-bit exit looks at the flag again; a mid-frame change is ignored
          if (fifo.fifo_empty) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = FETCH;
          end
        end else begin
          baud_next_s = baud_r + BW'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered versions line up with the state
  always_comb begin
    tx_next_s         = 1'b1;
    busy_next_s       = (state_next_s != IDLE);
    r_en_next_s       = (state_next_s == FETCH);
    frame_done_next_s = (state_next_s == STOP) && (baud_next_s == BAUD_LAST);
    case (state_next_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_next_s = parity_r;
`endif
      default: tx_next_s = 1'b1;
    endcase
  end

  // State, counters, shifter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      baud_r         <= '0;
      bit_r          <= 3'd0;
      shift_r        <= 8'd0;
      tx             <= 1'b1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      fifo.fifo_r_en <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      baud_r         <= baud_next_s;
      bit_r          <= bit_next_s;
      shift_r        <= shift_next_s;
      tx             <= tx_next_s;
      busy           <= busy_next_s;
      frame_done     <= frame_done_next_s;
      fifo.fifo_r_en <= r_en_next_s;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx with a FIFO model and a frame-level reference model.
// Honours FIFO_UART_TX_PARITY_EN the same way the design does.
module tb_fifo_uart_tx;
  localparam int CPB  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB     = 11;
  localparam int FD_OFS = 45;
`else
  localparam int NB     = 10;
  localparam int FD_OFS = 41;
`endif
  localparam int LAST_T = 1 + NB * CPB;
  localparam int MAXC   = 40000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic busy;
  logic frame_done;

  fifo_uart_tx_if ifc ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo       (ifc),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] wq[$];
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] rnd_q[$];
  bit         tx_log[0:MAXC-1];
  int         ren_q[$];
  int         fd_q[$];
  int         bfall_q[$];
  bit         prev_busy = 1'b0;

  // reference model: frame activity measured as an offset t from the pop cycle
  bit act = 1'b0;
  int t   = 0;
  bit mbits[0:10];

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, actual, required);
    end
  endtask

  // FIFO: pop on r_en, writes become visible after the edge
  always @(posedge clk) begin
    if (ifc.fifo_r_en && fq.size() > 0) ifc.fifo_data <= fq.pop_front();
    while (wq.size() > 0) fq.push_back(wq.pop_front());
    ifc.fifo_empty <= (fq.size() == 0);
  end

  task automatic start_frame();
    logic [7:0] b;
    act = 1'b1;
    t   = 0;
    if (exp_q.size() == 0) begin
      check("model_has_byte", 0, 1);
      b = 8'h00;
    end else begin
      b = exp_q.pop_front();
    end
    mbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) mbits[i+1] = b[i];
    mbits[9]    = ^b;
    mbits[NB-1] = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit e);
    if (r) begin
      act = 1'b0;
      t   = 0;
    end else if (!act || t == LAST_T) begin
      if (!e) start_frame();
      else act = 1'b0;
    end else begin
      t++;
    end
  endtask

  function automatic bit get_tx(input int i);
    if (i < 0 || i >= MAXC) return 1'b1;
    return tx_log[i];
  endfunction

  function automatic logic [7:0] decode(input int s);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = get_tx(s + (i + 1) * CPB + CPB / 2);
    return d;
  endfunction

  // compare process: model advances on the rising edge, outputs checked on the falling edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(rst, ifc.fifo_empty);
      @(negedge clk);
      check("tx",         int'(tx),            (act && t >= 2) ? int'(mbits[(t - 2) / CPB]) : 1);
      check("busy",       int'(busy),          int'(act));
      check("fifo_r_en",  int'(ifc.fifo_r_en), int'(act && t == 0));
      check("frame_done", int'(frame_done),    int'(act && t == LAST_T));
      if (ifc.fifo_r_en) check("no_underflow", int'(fq.size() > 0), 1);
      if (cyc < MAXC) tx_log[cyc] = tx;
      if (ifc.fifo_r_en) ren_q.push_back(cyc);
      if (frame_done) fd_q.push_back(cyc);
      if (prev_busy && !busy) bfall_q.push_back(cyc);
      prev_busy = busy;
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wq.push_back(b);
    exp_q.push_back(b);
    tick();
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (!(wq.size() == 0 && ifc.fifo_empty === 1'b1 && busy === 1'b0) && n < max) begin
      tick();
      n++;
    end
    check(name, int'(n < max), 1);
  endtask

  initial begin
    int         c0, base, fbase, r, n;
    logic [10:0] pat;
    logic [7:0]  b;

    // reset held two cycles with data waiting
    tick();
    push(8'hA5);
    repeat (2) begin
      tick();
      check("rst_tx", int'(tx), 1);
      check("rst_r_en", int'(ifc.fifo_r_en), 0);
      check("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    c0  = cyc;
    wait_idle(300, "a5_timeout");
    check("first_pop_latency", ren_q[0], c0 + 1);
    check("a5_pops", ren_q.size(), 1);
    check("a5_frame_done_count", fd_q.size(), 1);
    check("a5_frame_done_offset", fd_q[0] - ren_q[0], FD_OFS);
`ifdef FIFO_UART_TX_PARITY_EN
    pat = 11'b10101001010;
`else
    pat = 11'b01101001010;
`endif
    for (int k = 0; k < NB; k++)
      check("a5_bit", int'(get_tx(ren_q[0] + 2 + k * CPB + 1)), int'(pat[k]));

    // empty FIFO: nothing happens for 100 cycles
    base = ren_q.size();
    repeat (100) begin
      tick();
      check("idle_tx", int'(tx), 1);
      check("idle_busy", int'(busy), 0);
    end
    check("idle_no_pop", ren_q.size(), base);

    // four preloaded bytes go out back to back
    base  = ren_q.size();
    fbase = fd_q.size();
    for (int k = 1; k <= 4; k++) push(8'(k));
    wait_idle(1000, "burst_timeout");
    check("burst_pops", ren_q.size() - base, 4);
    for (int k = 0; k < 4; k++)
      check("burst_byte", int'(decode(ren_q[base + k] + 2)), k + 1);
    for (int k = 1; k < 4; k++)
      check("burst_gap", ren_q[base + k] + 2 - fd_q[fbase + k - 1] - 1, 2);
    check("burst_busy_fall", bfall_q[bfall_q.size() - 1], fd_q[fbase + 3] + 1);

    // reset during data bit 3 of 0xFF; the following byte survives
    base  = ren_q.size();
    fbase = fd_q.size();
    push(8'hFF);
    push(8'h5A);
    n = 0;
    while (ren_q.size() <= base && n < 100) begin tick(); n++; end
    check("ff_pop_seen", int'(ren_q.size() > base), 1);
    r = (ren_q.size() > base) ? ren_q[base] : cyc;
    n = 0;
    while (cyc < r + 19 && n < 100) begin tick(); n++; end
    check("ff_bit3_level", int'(tx), 1);
    rst = 1'b1;
    tick();
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    tick();
    check("midrst_no_pop", ren_q.size(), base + 1);
    rst = 1'b0;
    wait_idle(500, "after_rst_timeout");
    check("after_rst_pops", ren_q.size() - base, 2);
    check("after_rst_frames", fd_q.size() - fbase, 1);
    if (ren_q.size() > base + 1)
      check("after_rst_byte", int'(decode(ren_q[base + 1] + 2)), 8'h5A);

    // random traffic through a 4-deep FIFO
    base = ren_q.size();
    n    = 0;
    while (rnd_q.size() < 40 && n < 20000) begin
      if (fq.size() + wq.size() < 4 && $urandom_range(0, 2) != 0) begin
        b = 8'($urandom_range(0, 255));
        rnd_q.push_back(b);
        push(b);
      end else begin
        tick();
      end
      n++;
    end
    wait_idle(3000, "random_timeout");
    check("random_pops", ren_q.size() - base, rnd_q.size());
    for (int k = 0; k < rnd_q.size() && base + k < ren_q.size(); k++)
      check("random_byte", int'(decode(ren_q[base + k] + 2)), int'(rnd_q[k]));

`ifdef FIFO_UART_TX_PARITY_EN
    push(8'h07);
    wait_idle(300, "par07_timeout");
    r = ren_q[ren_q.size() - 1];
    check("par07_bit", int'(get_tx(r + 2 + 9 * CPB + 1)), 1);
    check("par07_length", fd_q[fd_q.size() - 1] - (r + 2) + 1, 44);
    push(8'h03);
    wait_idle(300, "par03_timeout");
    r = ren_q[ren_q.size() - 1];
    check("par03_bit", int'(get_tx(r + 2 + 9 * CPB + 1)), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
